// File: rtl/m_issue_pkg.sv
// Shared types and decode helpers for the M-extension issue controller.
package m_issue_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } m_issue_state_t;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   function automatic logic is_m_instr(input logic [31:0] instr);
      return (instr[6:0] == OPC_OP) && (instr[31:25] == F7_MULDIV);
   endfunction

endpackage

// File: rtl/m_issue_timer.sv
// Saturating wait counter; expired holds once the count reaches MAX_COUNT.
module m_issue_timer
   import m_issue_pkg::*;
#(
   parameter int MAX_COUNT = 64,
   parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != MAX_VAL)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == MAX_VAL);

endmodule

// File: rtl/m_issue_ctrl.sv
// Core-side PCPI initiator for RV32M: stalls execute, issues to the M unit,
// and returns a one-cycle writeback, with flush and timeout recovery.
module m_issue_ctrl
   import m_issue_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   input  logic [31:0] ex_instr,
   input  logic [31:0] ex_rs1_val,
   input  logic [31:0] ex_rs2_val,
   input  logic [4:0]  ex_rd,
   input  logic        flush,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   output logic [31:0] pcpi_rs1,
   output logic [31:0] pcpi_rs2,
   output logic [4:0]  pcpi_rd,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd_data,
   input  logic        pcpi_busy,
   input  logic        pcpi_ready,
   input  logic [4:0]  pcpi_dest,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        trap,
   output logic        dest_err
);

   m_issue_state_t r_state;
   m_issue_state_t w_nextState;

   logic        r_pcpiValid;
   logic [31:0] r_pcpiInsn;
   logic [31:0] r_pcpiRs1;
   logic [31:0] r_pcpiRs2;
   logic [4:0]  r_pcpiRd;
   logic        r_wbEn;
   logic [4:0]  r_wbRd;
   logic [31:0] r_wbData;
   logic        r_trap;
   logic        r_destErr;
   logic        r_quiet;

   logic w_isM;
   logic w_quiet;
   logic w_expired;
   logic w_issue;
   logic w_accept;
   logic w_abort;
   logic w_timeout;

   assign w_isM   = ex_valid & is_m_instr(ex_instr);
   assign w_quiet = ~pcpi_busy & ~pcpi_ready;

   m_issue_timer #(
      .MAX_COUNT (TIMEOUT_CYCLES),
      .CNT_W     (CNT_W)
   ) u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .i_clear   (w_issue),
      .i_enable  (r_state == WAIT),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // In WAIT a ready response outranks flush, which outranks timeout.
   always_comb begin
      w_nextState = r_state;
      stall       = 1'b0;
      w_issue     = 1'b0;
      w_accept    = 1'b0;
      w_abort     = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            stall = w_isM & ~flush;
            if (w_isM && !flush) begin
               w_issue     = 1'b1;
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (pcpi_ready) begin
               w_accept    = 1'b1;
               w_nextState = DONE;
            end else if (flush) begin
               w_abort     = 1'b1;
               w_nextState = DRAIN;
            end else if (w_expired) begin
               w_timeout   = 1'b1;
               w_nextState = DRAIN;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         DRAIN: begin
            stall = w_isM;
            if (pcpi_ready || (r_quiet && w_quiet)) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // r_quiet remembers one idle responder cycle so DRAIN can give up after two.
   always_ff @(posedge clk) begin
      if (resetn) begin
         r_pcpiValid <= 1'b0;
         r_pcpiInsn  <= '0;
         r_pcpiRs1   <= '0;
         r_pcpiRs2   <= '0;
         r_pcpiRd    <= '0;
         r_wbEn      <= 1'b0;
         r_wbRd      <= '0;
         r_wbData    <= '0;
         r_trap      <= 1'b0;
         r_destErr   <= 1'b0;
         r_quiet     <= 1'b0;
      end else begin
         r_wbEn    <= 1'b0;
         r_trap    <= 1'b0;
         r_destErr <= 1'b0;
         r_quiet   <= (r_state == DRAIN) && (w_nextState == DRAIN) && w_quiet;
         if (w_issue) begin
            r_pcpiValid <= 1'b1;
            r_pcpiInsn  <= ex_instr;
            r_pcpiRs1   <= ex_rs1_val;
            r_pcpiRs2   <= ex_rs2_val;
            r_pcpiRd    <= ex_rd;
         end
         if (w_accept) begin
            r_pcpiValid <= 1'b0;
            if (pcpi_wr) begin
               r_wbEn   <= 1'b1;
               r_wbRd   <= r_pcpiRd;
               r_wbData <= pcpi_rd_data;
            end
            if (pcpi_dest != r_pcpiRd) begin
               r_destErr <= 1'b1;
            end
         end
         if (w_abort) begin
            r_pcpiValid <= 1'b0;
         end
         if (w_timeout) begin
            r_trap      <= 1'b1;
            r_pcpiValid <= 1'b0;
         end
      end
   end

   assign pcpi_valid = r_pcpiValid;
   assign pcpi_insn  = r_pcpiInsn;
   assign pcpi_rs1   = r_pcpiRs1;
   assign pcpi_rs2   = r_pcpiRs2;
   assign pcpi_rd    = r_pcpiRd;
   assign wb_en      = r_wbEn;
   assign wb_rd      = r_wbRd;
   assign wb_data    = r_wbData;
   assign trap       = r_trap;
   assign dest_err   = r_destErr;

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Bench for m_issue_ctrl: scripted pipeline, behavioural M unit and a
// writeback scoreboard, plus a short-timeout instance with a silent responder.
module tb_m_issue_ctrl;
   import m_issue_pkg::*;

   localparam int T_SHORT = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn = 1'b1;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_instr = '0;
   logic [31:0] ex_rs1_val = '0;
   logic [31:0] ex_rs2_val = '0;
   logic [4:0]  ex_rd = '0;
   logic        flush = 1'b0;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic [4:0]  pcpi_rd;
   logic        pcpi_wr = 1'b0;
   logic [31:0] pcpi_rd_data = '0;
   logic        pcpi_busy = 1'b0;
   logic        pcpi_ready = 1'b0;
   logic [4:0]  pcpi_dest = '0;
   logic        stall, wb_en, trap, dest_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic        tValid = 1'b0;
   logic [31:0] tInstr = '0;
   logic        zero1 = 1'b0;
   logic [31:0] zero32 = '0;
   logic [4:0]  zero5 = '0;
   logic        tPcpiValid, tStall, tWbEn, tTrap, tDestErr;
   logic [31:0] tPcpiInsn, tPcpiRs1, tPcpiRs2, tWbData;
   logic [4:0]  tPcpiRd, tWbRd;

   m_issue_ctrl dut (
      .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_instr(ex_instr),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .flush(flush),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1),
      .pcpi_rs2(pcpi_rs2), .pcpi_rd(pcpi_rd), .pcpi_wr(pcpi_wr),
      .pcpi_rd_data(pcpi_rd_data), .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready),
      .pcpi_dest(pcpi_dest), .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .trap(trap), .dest_err(dest_err)
   );

   m_issue_ctrl #(.TIMEOUT_CYCLES(T_SHORT)) dutT (
      .clk(clk), .resetn(resetn), .ex_valid(tValid), .ex_instr(tInstr),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .flush(flush),
      .pcpi_valid(tPcpiValid), .pcpi_insn(tPcpiInsn), .pcpi_rs1(tPcpiRs1),
      .pcpi_rs2(tPcpiRs2), .pcpi_rd(tPcpiRd), .pcpi_wr(zero1),
      .pcpi_rd_data(zero32), .pcpi_busy(zero1), .pcpi_ready(zero1),
      .pcpi_dest(zero5), .stall(tStall), .wb_en(tWbEn), .wb_rd(tWbRd),
      .wb_data(tWbData), .trap(tTrap), .dest_err(tDestErr)
   );

   int checks = 0;
   int failures = 0;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        destErr;
   } wbExp_t;

   wbExp_t sbQ[$];
   wbExp_t monExp;

   // Behavioural M unit: starts on a pcpi_valid rise, replies after its latency,
   // and keeps going even if the requester flushes or resets meanwhile.
   int          rspLatency = 1;
   int          rspLatCur = 1;
   bit          rspBadDest = 1'b0;
   bit          rspActive = 1'b0;
   int          rspCnt = 0;
   logic [31:0] rspResult = '0;
   logic [4:0]  rspDest = '0;
   logic        rspPrevValid = 1'b0;

   always @(posedge clk) begin
      #1;
      pcpi_ready = 1'b0;
      pcpi_wr    = 1'b0;
      if (rspActive) begin
         rspCnt++;
         if (rspCnt >= rspLatCur) begin
            pcpi_ready   = 1'b1;
            pcpi_wr      = 1'b1;
            pcpi_rd_data = rspResult;
            pcpi_dest    = rspDest;
            pcpi_busy    = 1'b0;
            rspActive    = 1'b0;
         end
      end
      if ((pcpi_valid === 1'b1) && (rspPrevValid !== 1'b1)) begin
         rspActive = 1'b1;
         rspCnt    = 0;
         rspLatCur = rspLatency;
         pcpi_busy = 1'b1;
         case (pcpi_insn[14:12])
            3'b000:  rspResult = pcpi_rs1 * pcpi_rs2;
            3'b100:  rspResult = $signed(pcpi_rs1) / $signed(pcpi_rs2);
            3'b101:  rspResult = pcpi_rs1 / pcpi_rs2;
            default: rspResult = '0;
         endcase
         rspDest = rspBadDest ? (pcpi_rd ^ 5'd1) : pcpi_rd;
      end
      rspPrevValid = pcpi_valid;
   end

   // Monitor on the falling edge: scoreboard pops, stall run length, request
   // gaps and operand stability while a request is outstanding.
   int          stallRun = 0;
   int          lastStall = 0;
   int          lowRun = 0;
   bit          seenReq = 1'b0;
   bit          tWbSeen = 1'b0;
   logic [31:0] holdRs1 = '0, holdRs2 = '0, holdInsn = '0;
   logic [4:0]  holdRd = '0;
   logic        prevValid = 1'b0;

   always @(negedge clk) begin
      if (wb_en === 1'b1) begin
         checkOutput("wb_stall_low", 64'(stall), 64'd0);
         checkOutput("wb_operand_hold", {pcpi_rs1, pcpi_rs2}, {holdRs1, holdRs2});
         if (sbQ.size() == 0) begin
            checkOutput("wb_spurious", 64'(wb_en), 64'd0);
         end else begin
            monExp = sbQ.pop_front();
            checkOutput("wb_rd", 64'(wb_rd), 64'(monExp.rd));
            checkOutput("wb_data", 64'(wb_data), 64'(monExp.data));
            checkOutput("wb_dest_err", 64'(dest_err), 64'(monExp.destErr));
         end
      end
      if (stall === 1'b1) begin
         stallRun++;
      end else begin
         if (stallRun != 0) lastStall = stallRun;
         stallRun = 0;
      end
      if ((pcpi_valid === 1'b1) && (prevValid !== 1'b1)) begin
         if (seenReq) checkOutput("valid_gap", 64'(lowRun != 0), 64'd1);
         seenReq  = 1'b1;
         lowRun   = 0;
         holdRs1  = pcpi_rs1;
         holdRs2  = pcpi_rs2;
         holdInsn = pcpi_insn;
         holdRd   = pcpi_rd;
      end else if (pcpi_valid === 1'b1) begin
         checkOutput("operand_hold", {pcpi_rs1, pcpi_rs2}, {holdRs1, holdRs2});
         checkOutput("insn_hold", {27'd0, pcpi_rd, pcpi_insn}, {27'd0, holdRd, holdInsn});
      end else begin
         lowRun++;
      end
      if (tWbEn === 1'b1) tWbSeen = 1'b1;
      prevValid = pcpi_valid;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] mkR(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, OPC_OP};
   endfunction

   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
      ex_valid   = 1'b1;
      ex_instr   = instr;
      ex_rs1_val = a;
      ex_rs2_val = b;
      ex_rd      = rd;
   endtask

   task automatic waitWb(input string tag, input int budget, input int expStall);
      int n = 0;
      while ((wb_en !== 1'b1) && (n < budget)) begin
         step();
         n++;
      end
      checkOutput({tag, "_wb_seen"}, 64'(wb_en), 64'd1);
      step();
      ex_valid = 1'b0;
      if (expStall >= 0) checkOutput({tag, "_stall_len"}, 64'(lastStall), 64'(expStall));
   endtask

   task automatic runM(input string tag, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int lat,
                       input logic [31:0] result, input logic badDest);
      rspLatency = lat;
      rspBadDest = badDest;
      sbQ.push_back('{rd, result, badDest});
      applyStimulus(instr, a, b, rd);
      step();
      checkOutput({tag, "_issue"}, {31'd0, pcpi_valid, pcpi_insn}, {31'd0, 1'b1, instr});
      checkOutput({tag, "_operands"}, {pcpi_rs1, pcpi_rs2}, {a, b});
      waitWb(tag, lat + 10, lat + 2);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      logic [31:0] mulI, divI, divuI, addI;
      mulI  = mkR(F7_MULDIV, 3'b000, 5'd0);
      divI  = mkR(F7_MULDIV, 3'b100, 5'd0);
      divuI = mkR(F7_MULDIV, 3'b101, 5'd0);
      addI  = mkR(7'b0000000, 3'b000, 5'd0);

      $display("[TB] reset");
      repeat (3) step();
      resetn = 1'b0;
      checkOutput("rst_ctrl", 64'({pcpi_valid, pcpi_rd, wb_en, wb_rd, trap, dest_err, stall}), 64'd0);
      checkOutput("rst_operands", {pcpi_rs1, pcpi_rs2}, 64'd0);
      checkOutput("rst_insn_data", {pcpi_insn, wb_data}, 64'd0);
      checkOutput("rst_state", 64'(dut.r_state), 64'(IDLE));
      checkOutput("rst_t_ctrl", 64'({tPcpiValid, tPcpiRd, tWbEn, tWbRd, tTrap, tDestErr, tStall}), 64'd0);
      checkOutput("rst_t_data", {tPcpiRs1 | tPcpiRs2, tPcpiInsn | tWbData}, 64'd0);

      $display("[TB] MUL x5 = 7*6");
      runM("mul", mulI | (32'd5 << 7), 32'd7, 32'd6, 5'd5, 1, 32'd42, 1'b0);

      $display("[TB] DIVU 100/7 with 33 busy cycles");
      runM("divu", divuI | (32'd6 << 7), 32'd100, 32'd7, 5'd6, 33, 32'd14, 1'b0);

      $display("[TB] back-to-back MULs");
      runM("b2b_a", mulI | (32'd3 << 7), 32'd6, 32'd6, 5'd3, 1, 32'd36, 1'b0);
      runM("b2b_b", mulI | (32'd4 << 7), 32'd3, 32'd3, 5'd4, 1, 32'd9, 1'b0);

      $display("[TB] destination echo mismatch");
      runM("mul_dest", mulI | (32'd9 << 7), 32'd4, 32'd5, 5'd9, 2, 32'd20, 1'b1);
      rspBadDest = 1'b0;

      $display("[TB] flush on 5th WAIT cycle of DIV");
      rspLatency = 12;
      applyStimulus(divI | (32'd6 << 7), 32'd50, 32'd5, 5'd6);
      step();
      checkOutput("div_issue", 64'(pcpi_valid), 64'd1);
      repeat (4) step();
      checkOutput("div_wait5", 64'(dut.r_state), 64'(WAIT));
      flush = 1'b1;
      step();
      flush = 1'b0;
      applyStimulus(addI | (32'd8 << 7), 32'd1, 32'd2, 5'd8);
      #1;
      checkOutput("drain_add_stall", 64'(stall), 64'd0);
      checkOutput("drain_valid_low", 64'(pcpi_valid), 64'd0);
      checkOutput("drain_state", 64'(dut.r_state), 64'(DRAIN));
      step();
      rspLatency = 1;
      sbQ.push_back('{5'd7, 32'd6, 1'b0});
      applyStimulus(mulI | (32'd7 << 7), 32'd2, 32'd3, 5'd7);
      #1;
      checkOutput("drain_m_stall", 64'(stall), 64'd1);
      waitWb("drain_mul", 40, -1);

      $display("[TB] ADD and flushed MUL in IDLE");
      applyStimulus(addI | (32'd10 << 7), 32'd3, 32'd4, 5'd10);
      #1;
      checkOutput("add_stall", 64'(stall), 64'd0);
      step();
      checkOutput("add_no_issue", 64'(pcpi_valid), 64'd0);
      applyStimulus(mulI | (32'd10 << 7), 32'd3, 32'd4, 5'd10);
      flush = 1'b1;
      #1;
      checkOutput("flush_idle_stall", 64'(stall), 64'd0);
      step();
      checkOutput("flush_idle_no_issue", 64'(pcpi_valid), 64'd0);
      ex_valid = 1'b0;
      flush    = 1'b0;

      $display("[TB] reset during WAIT");
      rspLatency = 20;
      applyStimulus(mulI | (32'd11 << 7), 32'd9, 32'd9, 5'd11);
      step();
      checkOutput("rstw_issue", 64'(pcpi_valid), 64'd1);
      repeat (3) step();
      resetn   = 1'b1;
      ex_valid = 1'b0;
      step();
      resetn = 1'b0;
      checkOutput("rstw_ctrl", 64'({pcpi_valid, pcpi_rd, wb_en, wb_rd, trap, dest_err, stall}), 64'd0);
      checkOutput("rstw_operands", {pcpi_rs1, pcpi_rs2}, 64'd0);
      checkOutput("rstw_state", 64'(dut.r_state), 64'(IDLE));
      repeat (25) step();
      checkOutput("rstw_late_ready_ignored", 64'({pcpi_valid, wb_en, wb_data}), 64'd0);
      checkOutput("rstw_still_idle", 64'(dut.r_state), 64'(IDLE));

      $display("[TB] timeout with silent responder");
      tInstr = mulI | (32'd12 << 7);
      tValid = 1'b1;
      step();
      checkOutput("t_issue", 64'(tPcpiValid), 64'd1);
      n = 0;
      while ((tTrap !== 1'b1) && (n < 30)) begin
         step();
         n++;
      end
      checkOutput("t_trap_seen", 64'(tTrap), 64'd1);
      checkOutput("t_trap_delay", 64'(n), 64'(T_SHORT + 1));
      checkOutput("t_valid_drop", 64'(tPcpiValid), 64'd0);
      tValid = 1'b0;
      step();
      checkOutput("t_trap_pulse", 64'(tTrap), 64'd0);
      step();
      checkOutput("t_idle", 64'(dutT.r_state), 64'(IDLE));
      checkOutput("t_no_wb", 64'(tWbSeen), 64'd0);

      repeat (3) step();
      checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/m_issue_ctrl.md
# m_issue_ctrl

Core-side initiator for the M-extension coprocessor interface. It detects RV32M instructions in the execute stage, stalls the pipeline, and drives the valid/instruction/operand handshake to the multiply/divide unit. It waits for the unit's ready/write response, then returns a single-cycle writeback to the register file. It also handles pipeline flushes and responder timeouts without leaving the responder in an inconsistent state.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles from issue to `pcpi_ready` before a trap is raised.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the wait counter.

Ports:
- clk  in  1  the only clock.
- resetn  in  1  synchronous, active-high reset, despite the name.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_instr  in  32  execute-stage instruction.
- ex_rs1_val  in  32  rs1 operand value.
- ex_rs2_val  in  32  rs2 operand value.
- ex_rd  in  5  destination register.
- flush  in  1  kill the current execute-stage instruction.
- pcpi_valid  out  1  request to the M unit.
- pcpi_insn  out  32  latched instruction.
- pcpi_rs1  out  32  latched rs1 value.
- pcpi_rs2  out  32  latched rs2 value.
- pcpi_rd  out  5  latched destination register.
- pcpi_wr  in  1  responder has a result to write.
- pcpi_rd_data  in  32  responder result.
- pcpi_busy  in  1  responder is computing.
- pcpi_ready  in  1  responder is done (1-cycle pulse).
- pcpi_dest  in  5  responder's echoed destination register.
- stall  out  1  hold the pipeline.
- wb_en  out  1  register-file write pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- trap  out  1  1-cycle pulse on timeout.
- dest_err  out  1  1-cycle pulse when `pcpi_dest` does not match the latched rd at ready.

## Operation
- M detect: `is_m = ex_valid & (ex_instr[6:0]==7'b0110011) & (ex_instr[31:25]==7'b0000001)`.
- FSM states: IDLE, WAIT, DONE, DRAIN. Reset puts the FSM in IDLE and sets every output register to 0, including the latched operands.
- IDLE:
  - `stall = is_m & ~flush`, combinational.
  - On `is_m & ~flush`: latch instr, rs1, rs2 and rd into the pcpi registers, set `pcpi_valid=1`, clear the counter, go to WAIT.
- WAIT:
  - `stall=1`.
  - `pcpi_valid` and all pcpi operand outputs stay constant.
  - The counter increments each cycle.
  - Priority order: reset > `pcpi_ready` > flush > timeout.
  - On `pcpi_ready`: `pcpi_valid<=0`. If `pcpi_wr`, load `wb_data<=pcpi_rd_data`, `wb_rd<=pcpi_rd`, `wb_en<=1`. If `pcpi_dest!=pcpi_rd`, `dest_err<=1`. Go to DONE.
  - On flush without ready: `pcpi_valid<=0`, go to DRAIN.
  - On counter reaching TIMEOUT_CYCLES without ready: `trap<=1`, `pcpi_valid<=0`, go to DRAIN.
- DONE:
  - `stall=0`, and `wb_en` is high this cycle.
  - Unconditionally return to IDLE. No issue is possible in DONE, so `pcpi_valid` is low for at least one cycle between requests.
- DRAIN:
  - Waits for the responder's outstanding `pcpi_ready`, which is discarded: no `wb_en`.
  - `stall = is_m` (a new M instruction waits; other instructions proceed).
  - Go to IDLE on `pcpi_ready`, or when `pcpi_busy` and `pcpi_ready` are both low for 2 consecutive cycles (the responder never started).
- Flush in IDLE or DONE has no effect on this block beyond suppressing a new issue.
- `wb_en`, `trap` and `dest_err` are single-cycle pulses, cleared the following cycle.

## Timing
- Issue: `pcpi_valid` rises one cycle after `is_m` is seen in IDLE.
- Writeback latency: `wb_en` rises one cycle after `pcpi_ready`; `stall` falls in that same cycle.
- Total stall = 1 + responder latency + 1 cycles.
- Operands are stable from the `pcpi_valid` rise until the cycle after `pcpi_ready`, so the responder may capture at any point in that window.
- Timeout: with no ready, `trap` pulses exactly TIMEOUT_CYCLES+1 cycles after `pcpi_valid` rises.
- Reset asserted mid-WAIT or mid-DRAIN: the next cycle is IDLE with all outputs 0, and no writeback occurs.
- A `pcpi_ready` arriving in IDLE or DONE is ignored.

## Structure
- Shared package `m_issue_pkg`:
  - state enum `m_issue_state_t` (IDLE, WAIT, DONE, DRAIN);
  - constants `OPC_OP=7'b0110011` and `F7_MULDIV=7'b0000001`;
  - function `is_m_instr(logic[31:0])`.
- One sub-module is natural: `m_issue_timer`, the saturating wait counter with clear, enable and `expired` output.
- The FSM, operand latch and writeback registers stay in the top module.

## Test plan
- MUL x5, x1=7, x2=6, responder ready+wr 1 cycle after valid -> `wb_en` 1 cycle, `wb_rd=5`, `wb_data=42`, total stall 3 cycles.
- DIVU, x1=100, x2=7, responder busy for 33 cycles -> `pcpi_rs1/rs2` held constant throughout, `wb_data=14`, `stall` falls with `wb_en`.
- Two back-to-back MULs -> `pcpi_valid` low for at least 1 cycle between requests, and both writebacks correct (6*6=36, then 3*3=9).
- Flush on the 5th WAIT cycle of a DIV -> no `wb_en`, a later `pcpi_ready` is discarded in DRAIN, an ADD proceeds unstalled during DRAIN.
- Responder never replies, TIMEOUT_CYCLES=8 -> `trap` pulses 9 cycles after `pcpi_valid` rises, no `wb_en`, FSM returns to IDLE.
- ADD instruction (funct7=0), plus reset asserted mid-WAIT -> no `pcpi_valid` or stall for the ADD; after the reset, all outputs are 0 and the FSM is in IDLE.
